dm_unit: RTL and testbench

Parametrised data-memory unit for the single-cycle/pipelined MIPS datapath, successor to the fixed 1024-word store-word-only data memory. It adds byte/halfword/word stores with lane merging, signed/unsigned sub-word loads, misalignment detection, and a valid/ready request port with a configurable response latency. It sits between the execute/memory stage and the write-back mux; the optional store trace keeps the course-standard `$display` format.

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_lane_ext.sv | 35 +++
 rtl/dm_unit.sv | 130 +++++++++++++
 tb/tb_dm_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared size encodings, FSM state type and request-error predicate for dm_unit
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } dm_state_e;

  // Illegal size, or a half/word whose byte address is not naturally aligned.
  function automatic logic dm_req_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = addr_lo[0];
      SZ_W:    err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// rtl/dm_lane_ext.sv - combinational byte/half extraction with sign or zero extension
module dm_lane_ext
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_B:    data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      SZ_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// rtl/dm_unit.sv - data memory with lane-merged stores, extended loads and latency FSM; DM_TRACE_EN enables store trace
module dm_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem_q [DEPTH];

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [ADDR_W-1:0] idx;
  logic [31:0]       old_word;
  logic [31:0]       ext_word;
  logic [31:0]       wdata_rep;
  logic [31:0]       merged_word;
  logic [3:0]        lane_en;
  logic              fire;
  logic              req_err;
  logic              unused_ok;

  assign idx       = req_addr[ADDR_W+1:2];
  assign old_word  = mem_q[idx];
  assign req_err   = dm_req_err(req_size, req_addr[1:0]);
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign fire      = req_valid && req_ready;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign unused_ok = ^{req_pc, req_addr[31:ADDR_W+2]};

  dm_lane_ext u_lane_ext (
    .word_i    (old_word),
    .addr_lo_i (req_addr[1:0]),
    .size_i    (req_size),
    .signed_i  (req_signed),
    .data_o    (ext_word)
  );

  // Right-aligned store data is replicated so every lane sees its candidate byte.
  always_comb begin
    lane_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      SZ_B: begin
        lane_en[req_addr[1:0]] = 1'b1;
        wdata_rep              = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_W:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = lane_en[i] ? wdata_rep[8*i +: 8] : old_word[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rdata_d = (req_we || req_err) ? 32'd0 : ext_word;
          err_d   = req_err;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (fire && req_we && !req_err) begin
        mem_q[idx] <= merged_word;
`ifdef DM_TRACE_EN
        $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged_word);
`endif
      end
    end
  end

endmodule

// File: tb/tb_dm_unit.sv
// tb/tb_dm_unit.sv - randomized and directed bench for dm_unit at LATENCY 1 and 4 against a byte-array model
module tb_dm_unit;

  logic        clk = 1'b0;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] req_pc     [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int checks = 0;
  int errors = 0;

  byte unsigned mbytes [2][4096];

  always #5 clk = ~clk;

  dm_unit #(.ADDR_W(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_pc(req_pc[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dm_unit #(.ADDR_W(10), .LATENCY(4)) dut_l4 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_pc(req_pc[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int lat(input int w);
    return (w == 0) ? 1 : 4;
  endfunction

  function automatic void model_clear(input int w);
    for (int i = 0; i < 4096; i++) mbytes[w][i] = 8'd0;
  endfunction

  // Memory as a flat little-endian byte array; accesses are naturally aligned units of 1<<size bytes.
  function automatic void model_access(input int w, input bit we, input logic [1:0] size, input bit sgn,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output bit er);
    int n;
    int base;
    longint v;
    rd = 32'd0;
    er = 1'b0;
    n = 1 << size;
    if (size == 2'b11 || (int'(addr[1:0]) % n) != 0) begin
      er = 1'b1;
      return;
    end
    base = int'(addr[11:0]);
    if (we) begin
      for (int i = 0; i < n; i++) mbytes[w][base + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(mbytes[w][base + i]) << (8 * i));
      if (sgn && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      rd = v[31:0];
    end
  endfunction

  task automatic set_rand(input int w);
    int r;
    r = $urandom_range(0, 9);
    req_size[w]   = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    req_we[w]     = $urandom_range(0, 1);
    req_signed[w] = $urandom_range(0, 1);
    req_wdata[w]  = $urandom;
    req_pc[w]     = $urandom;
    req_addr[w]   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0 && req_size[w] != 2'b11)
      req_addr[w] = req_addr[w] & ~((32'd1 << req_size[w]) - 32'd1);
  endtask

  task automatic do_req(input int w, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
    logic [31:0] er;
    bit          ee;
    int          n;
    @(negedge clk);
    req_valid[w] = 1'b1; req_we[w] = we; req_size[w] = size; req_signed[w] = sgn;
    req_addr[w] = addr; req_wdata[w] = wdata; req_pc[w] = $urandom;
    checks++;
    if (req_ready[w] !== 1'b1) begin
      errors++; $display("FAIL ready_idle w=%0d got %b want 1", w, req_ready[w]);
    end
    model_access(w, we, size, sgn, addr, wdata, er, ee);
    @(posedge clk); #1;
    req_valid[w] = 1'b0; req_addr[w] = $urandom; req_wdata[w] = $urandom; req_we[w] = $urandom_range(0, 1);
    n = 1;
    while (rsp_valid[w] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    got = rsp_rdata[w];
    checks++;
    if (n !== lat(w)) begin
      errors++; $display("FAIL latency w=%0d addr=%h got %0d want %0d", w, addr, n, lat(w));
    end
    checks++;
    if (rsp_rdata[w] !== er) begin
      errors++; $display("FAIL rdata w=%0d we=%0d sz=%0d addr=%h got %h want %h", w, we, size, addr, rsp_rdata[w], er);
    end
    checks++;
    if (rsp_err[w] !== ee) begin
      errors++; $display("FAIL err w=%0d sz=%0d addr=%h got %b want %b", w, size, addr, rsp_err[w], ee);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[w] !== 1'b0 || req_ready[w] !== 1'b1 || rsp_rdata[w] !== er) begin
      errors++; $display("FAIL pulse_hold w=%0d got v=%b r=%b d=%h want v=0 r=1 d=%h",
                         w, rsp_valid[w], req_ready[w], rsp_rdata[w], er);
    end
  endtask

  task automatic test_reset;
    for (int w = 0; w < 2; w++) begin
      reset[w] = 1'b1; req_valid[w] = 1'b0; req_we[w] = 1'b0; req_size[w] = 2'b10;
      req_signed[w] = 1'b0; req_addr[w] = 32'd0; req_wdata[w] = 32'd0; req_pc[w] = 32'd0;
      model_clear(w);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) reset[w] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (rsp_valid[w] !== 1'b0 || rsp_err[w] !== 1'b0 || rsp_rdata[w] !== 32'd0 || req_ready[w] !== 1'b1) begin
        errors++; $display("FAIL reset_state w=%0d got v=%b e=%b d=%h r=%b want 0 0 0 1",
                           w, rsp_valid[w], rsp_err[w], rsp_rdata[w], req_ready[w]);
      end
    end
  endtask

  task automatic test_directed_l1;
    logic [31:0] got;
    do_req(0, 0, 2'b10, 0, 32'h0, 32'h0, got);
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL lw0 got %h want 00000000", got); end
    do_req(0, 1, 2'b10, 0, 32'h10, 32'h8000_00F0, got);
    do_req(0, 1, 2'b00, 0, 32'h13, 32'h7F, got);
    do_req(0, 0, 2'b00, 1, 32'h13, 32'h0, got);
    checks++; if (got !== 32'h0000_007F) begin errors++; $display("FAIL lb13 got %h want 0000007f", got); end
    do_req(0, 0, 2'b00, 1, 32'h10, 32'h0, got);
    checks++; if (got !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb10 got %h want fffffff0", got); end
    do_req(0, 0, 2'b00, 0, 32'h10, 32'h0, got);
    checks++; if (got !== 32'h0000_00F0) begin errors++; $display("FAIL lbu10 got %h want 000000f0", got); end
    do_req(0, 1, 2'b10, 0, 32'h20, 32'h1234_5678, got);
    do_req(0, 1, 2'b01, 0, 32'h22, 32'hBEEF, got);
    do_req(0, 0, 2'b10, 0, 32'h20, 32'h0, got);
    checks++; if (got !== 32'hBEEF_5678) begin errors++; $display("FAIL sh_merge got %h want beef5678", got); end
    do_req(0, 0, 2'b01, 1, 32'h22, 32'h0, got);
    checks++; if (got !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh22 got %h want ffffbeef", got); end
    do_req(0, 0, 2'b01, 0, 32'h22, 32'h0, got);
    checks++; if (got !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu22 got %h want 0000beef", got); end
  endtask

  task automatic test_errors;
    logic [31:0] got;
    do_req(0, 1, 2'b10, 0, 32'h4, 32'hCAFE_F00D, got);
    do_req(0, 0, 2'b10, 0, 32'h6, 32'h0, got);
    checks++; if (rsp_err[0] !== 1'b1) begin errors++; $display("FAIL lw6_err got %b want 1", rsp_err[0]); end
    do_req(0, 1, 2'b01, 0, 32'h5, 32'h1111, got);
    checks++; if (rsp_err[0] !== 1'b1) begin errors++; $display("FAIL sh5_err got %b want 1", rsp_err[0]); end
    do_req(0, 1, 2'b11, 0, 32'h4, 32'h2222_2222, got);
    checks++; if (rsp_err[0] !== 1'b1) begin errors++; $display("FAIL sz11_err got %b want 1", rsp_err[0]); end
    do_req(0, 0, 2'b10, 0, 32'h4, 32'h0, got);
    checks++; if (got !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_nowrite got %h want cafef00d", got); end
  endtask

  task automatic test_random;
    logic [31:0] got;
    for (int i = 0; i < 80; i++) begin
      set_rand(0);
      do_req(0, req_we[0], req_size[0], req_signed[0], req_addr[0], req_wdata[0], got);
    end
    for (int i = 0; i < 15; i++) begin
      set_rand(1);
      do_req(1, req_we[1], req_size[1], req_signed[1], req_addr[1], req_wdata[1], got);
    end
  endtask

  task automatic test_back_to_back;
    int          accepts [$];
    int          due     [$];
    logic [31:0] exp_d   [$];
    bit          exp_e   [$];
    logic [31:0] er;
    bit          ee;
    bit          fire;
    @(negedge clk);
    set_rand(1);
    req_valid[1] = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      fire = req_valid[1] && req_ready[1];
      @(posedge clk); #1;
      if (fire) begin
        model_access(1, req_we[1], req_size[1], req_signed[1], req_addr[1], req_wdata[1], er, ee);
        accepts.push_back(cyc);
        due.push_back(cyc + lat(1) - 1);
        exp_d.push_back(er);
        exp_e.push_back(ee);
        set_rand(1);
        if (accepts.size() == 6) req_valid[1] = 1'b0;
      end
      checks++;
      if (due.size() > 0 && due[0] == cyc) begin
        if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== exp_d[0] || rsp_err[1] !== exp_e[0]) begin
          errors++; $display("FAIL b2b_rsp cyc=%0d got v=%b d=%h e=%b want v=1 d=%h e=%b",
                             cyc, rsp_valid[1], rsp_rdata[1], rsp_err[1], exp_d[0], exp_e[0]);
        end
        void'(due.pop_front()); void'(exp_d.pop_front()); void'(exp_e.pop_front());
      end else if (rsp_valid[1] !== 1'b0) begin
        errors++; $display("FAIL b2b_idle cyc=%0d got rsp_valid %b want 0", cyc, rsp_valid[1]);
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    checks++;
    if (accepts.size() != 6 || due.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d accepts %0d pending want 6 and 0", accepts.size(), due.size());
    end
    for (int i = 1; i < accepts.size(); i++) begin
      checks++;
      if (accepts[i] - accepts[i-1] != lat(1) + 1) begin
        errors++; $display("FAIL b2b_spacing idx=%0d got %0d want %0d", i, accepts[i] - accepts[i-1], lat(1) + 1);
      end
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] got;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10; req_signed[1] = 1'b0;
    req_addr[1] = 32'h80; req_wdata[1] = $urandom | 32'h1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset[1] = 1'b1;
    @(posedge clk); #1;
    reset[1] = 1'b0;
    model_clear(1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rsp_valid[1] !== 1'b0) begin
        errors++; $display("FAIL wait_reset_rsp cyc=%0d got %b want 0", i, rsp_valid[1]);
      end
      @(posedge clk); #1;
    end
    do_req(1, 0, 2'b10, 0, 32'h80, 32'h0, got);
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL wait_reset_mem got %h want 00000000", got); end
  endtask

  task automatic test_reset_with_valid;
    logic [31:0] got;
    @(negedge clk);
    reset[0] = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b10; req_addr[0] = 32'h40; req_wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset[0] = 1'b0; req_valid[0] = 1'b0;
    model_clear(0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid[0] !== 1'b0) begin
        errors++; $display("FAIL reset_valid_rsp cyc=%0d got %b want 0", i, rsp_valid[0]);
      end
      @(posedge clk); #1;
    end
    do_req(0, 0, 2'b10, 0, 32'h40, 32'h0, got);
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL reset_valid_mem got %h want 00000000", got); end
  endtask

  initial begin
    test_reset();
    test_directed_l1();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_in_wait();
    test_reset_with_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
